// File: rtl/vga_timing_pkg.sv
// Shared raster constants and the phase encoding used by both axes
// and by the downstream renderer.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CNT_W_DEF    = 10;

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_e;

endpackage

// File: rtl/vga_axis_ctr.sv
// One raster axis: a wrapping counter plus its phase register,
// both advancing only on tick.
module vga_axis_ctr
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int CNT_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    output logic [CNT_W-1:0] count,
    output phase_e           phase,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [CNT_W-1:0] LAST_ACT  = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FP   = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST_BP   = CNT_W'(TOTAL - 1);

    assign wrap = tick && (count == LAST_BP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            phase <= PH_ACT;
        end else if (tick) begin
            count <= wrap ? '0 : count + 1'b1;
            unique case (phase)
                PH_ACT:  if (count == LAST_ACT)  phase <= PH_FP;
                PH_FP:   if (count == LAST_FP)   phase <= PH_SYNC;
                PH_SYNC: if (count == LAST_SYNC) phase <= PH_BP;
                PH_BP:   if (count == LAST_BP)   phase <= PH_ACT;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: syncs, data enable, pixel coordinates and
// line/frame strobes, all registered one cycle after the counters.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             dclk,
    input  logic             rst_n,
    input  logic             en,
    output logic             hs,
    output logic             vs,
    output logic             de,
    output logic [CNT_W-1:0] px_x,
    output logic [CNT_W-1:0] px_y,
    output logic             line_start,
    output logic             frame_start,
    output logic             frame_end
);

    localparam logic [CNT_W-1:0] V_ACT_CNT = CNT_W'(V_ACTIVE);

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;
    phase_e           h_ph;
    phase_e           v_ph;
    logic             h_wrap;
    logic             v_wrap;
    logic             unused_v_wrap;

    assign unused_v_wrap = v_wrap;

    vga_axis_ctr #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .CNT_W  (CNT_W)
    ) u_h (
        .clk   (dclk),
        .rst_n (rst_n),
        .tick  (en),
        .count (hcnt),
        .phase (h_ph),
        .wrap  (h_wrap)
    );

    // The vertical axis steps once per completed line.
    vga_axis_ctr #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .CNT_W  (CNT_W)
    ) u_v (
        .clk   (dclk),
        .rst_n (rst_n),
        .tick  (h_wrap),
        .count (vcnt),
        .phase (v_ph),
        .wrap  (v_wrap)
    );

    logic h_zero;
    assign h_zero = (hcnt == '0);

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            hs          <= ~SYNC_POL;
            vs          <= ~SYNC_POL;
            de          <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            if (en) begin
                hs          <= (h_ph == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
                vs          <= (v_ph == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
                de          <= (h_ph == PH_ACT) && (v_ph == PH_ACT);
                px_x        <= hcnt;
                px_y        <= vcnt;
                line_start  <= h_zero;
                frame_start <= h_zero && (vcnt == '0);
                frame_end   <= h_zero && (vcnt == V_ACT_CNT);
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: small and full-size rasters against an arithmetic position model,
// plus a vector table and freeze / async-reset sequences.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic       fe;
    } out_t;

    typedef struct {
        int   n;
        out_t e;
    } vec_t;

    logic dclk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    always #5 dclk = ~dclk;

    logic       s_hs, s_vs, s_de, s_ls, s_fs, s_fe;
    logic [5:0] s_x, s_y;
    logic       p_hs, p_vs, p_de, p_ls, p_fs, p_fe;
    logic [5:0] p_x, p_y;
    logic       d_hs, d_vs, d_de, d_ls, d_fs, d_fe;
    logic [9:0] d_x, d_y;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0), .CNT_W(6)
    ) dut_s (
        .dclk(dclk), .rst_n(rst_n), .en(en),
        .hs(s_hs), .vs(s_vs), .de(s_de),
        .px_x(s_x), .px_y(s_y),
        .line_start(s_ls), .frame_start(s_fs), .frame_end(s_fe)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .CNT_W(6)
    ) dut_p (
        .dclk(dclk), .rst_n(rst_n), .en(en),
        .hs(p_hs), .vs(p_vs), .de(p_de),
        .px_x(p_x), .px_y(p_y),
        .line_start(p_ls), .frame_start(p_fs), .frame_end(p_fe)
    );

    vga_timing_gen dut_d (
        .dclk(dclk), .rst_n(rst_n), .en(en),
        .hs(d_hs), .vs(d_vs), .de(d_de),
        .px_x(d_x), .px_y(d_y),
        .line_start(d_ls), .frame_start(d_fs), .frame_end(d_fe)
    );

    out_t act [3];
    assign act[0] = {4'b0, s_x, 4'b0, s_y, s_hs, s_vs, s_de, s_ls, s_fs, s_fe};
    assign act[1] = {4'b0, p_x, 4'b0, p_y, p_hs, p_vs, p_de, p_ls, p_fs, p_fe};
    assign act[2] = {d_x, d_y, d_hs, d_vs, d_de, d_ls, d_fs, d_fe};

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    function automatic out_t mk(int x, int y, bit hs, bit vs, bit de,
                                bit ls, bit fs, bit fe);
        out_t r;
        r.x  = 10'(x);
        r.y  = 10'(y);
        r.hs = hs;
        r.vs = vs;
        r.de = de;
        r.ls = ls;
        r.fs = fs;
        r.fe = fe;
        return r;
    endfunction

    // Expected outputs for the pixel at linear raster position pos.
    function automatic out_t ref_at(int pos, int ha, int hf, int hsw, int hb,
                                    int va, int vf, int vsw, int vb, bit pol);
        int ht = ha + hf + hsw + hb;
        int vt = va + vf + vsw + vb;
        int h = pos % ht;
        int v = (pos / ht) % vt;
        bit hsy = (h >= ha + hf) && (h < ha + hf + hsw);
        bit vsy = (v >= va + vf) && (v < va + vf + vsw);
        return mk(h, v, hsy ? pol : !pol, vsy ? pol : !pol,
                  (h < ha) && (v < va), h == 0,
                  (h == 0) && (v == 0), (h == 0) && (v == va));
    endfunction

    function automatic out_t model(int i, int pos);
        if (i == 2)
            return ref_at(pos, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
        return ref_at(pos, 8, 2, 3, 3, 4, 1, 2, 2, i == 1);
    endfunction

    function automatic out_t rst_val(bit pol);
        return mk(0, 0, !pol, !pol, 0, 0, 0, 0);
    endfunction

    task automatic check(string name, out_t a, out_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t got x=%0d y=%0d hs%b vs%b de%b ls%b fs%b fe%b want x=%0d y=%0d hs%b vs%b de%b ls%b fs%b fe%b",
                     name, $time, a.x, a.y, a.hs, a.vs, a.de, a.ls, a.fs, a.fe,
                     e.x, e.y, e.hs, e.vs, e.de, e.ls, e.fs, e.fe);
        end
    endtask

    out_t exp_o [3];
    int   pos = 0;

    always @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= 0;
            for (int i = 0; i < 3; i++) exp_o[i] <= rst_val(i == 1);
        end else if (en) begin
            pos <= pos + 1;
            for (int i = 0; i < 3; i++) exp_o[i] <= model(i, pos);
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp_o[i].ls <= 1'b0;
                exp_o[i].fs <= 1'b0;
                exp_o[i].fe <= 1'b0;
            end
        end
    end

    always @(negedge dclk) begin
        if (armed) begin
            check("model_s", act[0], exp_o[0]);
            check("model_p", act[1], exp_o[1]);
            check("model_d", act[2], exp_o[2]);
        end
    end

    task automatic step();
        @(negedge dclk);
        #1;
    endtask

    task automatic do_reset(int cyc);
        rst_n = 1'b0;
        repeat (cyc) step();
        en = 1'b1;
        rst_n = 1'b1;
    endtask

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1,   mk(0, 0, 1, 1, 1, 1, 1, 0)};
        tbl[1]  = '{8,   mk(7, 0, 1, 1, 1, 0, 0, 0)};
        tbl[2]  = '{9,   mk(8, 0, 1, 1, 0, 0, 0, 0)};
        tbl[3]  = '{11,  mk(10, 0, 0, 1, 0, 0, 0, 0)};
        tbl[4]  = '{13,  mk(12, 0, 0, 1, 0, 0, 0, 0)};
        tbl[5]  = '{14,  mk(13, 0, 1, 1, 0, 0, 0, 0)};
        tbl[6]  = '{17,  mk(0, 1, 1, 1, 1, 1, 0, 0)};
        tbl[7]  = '{65,  mk(0, 4, 1, 1, 0, 1, 0, 1)};
        tbl[8]  = '{81,  mk(0, 5, 1, 0, 0, 1, 0, 0)};
        tbl[9]  = '{98,  mk(1, 6, 1, 0, 0, 0, 0, 0)};
        tbl[10] = '{113, mk(0, 7, 1, 1, 0, 1, 0, 0)};
        tbl[11] = '{144, mk(15, 8, 1, 1, 0, 0, 0, 0)};
        tbl[12] = '{145, mk(0, 0, 1, 1, 1, 1, 1, 0)};

        step();
        rst_n = 1'b0;
        step();
        armed = 1'b1;
        repeat (4) step();
        check("reset_s", act[0], rst_val(1'b0));
        check("reset_p", act[1], rst_val(1'b1));
        check("reset_d", act[2], rst_val(1'b0));
        en = 1'b1;
        rst_n = 1'b1;
        step();
        check("first_edge", act[0], mk(0, 0, 1, 1, 1, 1, 1, 0));
        check("first_edge_d", act[2], mk(0, 0, 1, 1, 1, 1, 1, 0));

        for (int k = 0; k < 13; k++) begin
            do_reset(2);
            repeat (tbl[k].n) step();
            check($sformatf("vec%0d", k), act[0], tbl[k].e);
        end

        // Freeze on the last visible pixel of a line.
        do_reset(2);
        repeat (8) step();
        en = 1'b0;
        repeat (37) begin
            step();
            check("frozen", act[0], mk(7, 0, 1, 1, 1, 0, 0, 0));
        end
        en = 1'b1;
        step();
        check("resume", act[0], mk(8, 0, 1, 1, 0, 0, 0, 0));

        // Asynchronous reset between clock edges, mid-frame.
        do_reset(2);
        repeat (54) step();
        check("pre_areset", act[0], mk(5, 3, 1, 1, 1, 0, 0, 0));
        #1 rst_n = 1'b0;
        #1;
        check("areset_s", act[0], rst_val(1'b0));
        check("areset_p", act[1], rst_val(1'b1));
        check("areset_d", act[2], rst_val(1'b0));
        step();
        rst_n = 1'b1;
        step();
        check("restart", act[0], mk(0, 0, 1, 1, 1, 1, 1, 0));

        // Full-size raster: a little over three lines, enabled throughout.
        repeat (2500) step();

        // Randomised enable, with one reset in the middle.
        for (int r = 0; r < 1600; r++) begin
            en = ($urandom_range(0, 3) != 0);
            if (r == 800) rst_n = 1'b0;
            if (r == 803) rst_n = 1'b1;
            step();
        end

        armed = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
